// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with programmable wait states and a stall output.
// Define DMEM_ERR_EN to flag misaligned or out-of-range accesses instead of wrapping them.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [31:0] mem [DEPTH];

  logic          src_we;
  logic [31:0]   src_addr;
  logic [31:0]   src_wdata;
  logic [AW-1:0] src_idx;
  logic [AW-1:0] cap_idx;
  logic          src_err;
  logic [31:0]   resp_data;
  logic          unused_addr_bits;

  // The response is computed on the edge entering RESP: from the live inputs when
  // LATENCY=0 jumps straight out of IDLE, otherwise from the captured request.
  always_comb begin
    src_we    = cap_we;
    src_addr  = cap_addr;
    src_wdata = cap_wdata;
    if (state == IDLE) begin
      src_we    = we;
      src_addr  = addr;
      src_wdata = wdata;
    end
    src_idx = src_addr[AW+1:2];
    cap_idx = cap_addr[AW+1:2];
`ifdef DMEM_ERR_EN
    src_err = (src_addr[1:0] != 2'b00) || (src_addr >= 32'(DEPTH * 4));
`else
    src_err = 1'b0;
`endif
    if (src_err)
      resp_data = '0;
    else if (src_we)
      resp_data = src_wdata;
    else
      resp_data = mem[src_idx];
  end

  assign unused_addr_bits = &{1'b0, src_addr[31:AW+2], src_addr[1:0]};

  assign ready = (state == IDLE);
  assign busy  = req | (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rvalid <= 1'b0;
          if (req) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            if (LATENCY == 0) begin
              state  <= RESP;
              rvalid <= 1'b1;
              rdata  <= resp_data;
              err    <= src_err;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state  <= RESP;
            rvalid <= 1'b1;
            rdata  <= resp_data;
            err    <= src_err;
          end
        end
        RESP: begin
          state  <= IDLE;
          rvalid <= 1'b0;
          err    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A store commits on the edge leaving RESP; reset forces IDLE first, so an aborted store never writes.
  always_ff @(posedge clk) begin
    if (state == RESP && cap_we && !err)
      mem[cap_idx] <= cap_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance.
// The DMEM_ERR_EN build swaps the address-wrap scenario for the error scenario.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, req1, we1;
  logic [31:0] addr, wdata, addr1, wdata1;
  logic        ready, rvalid, busy, err;
  logic        ready1, rvalid1, busy1, err1;
  logic [31:0] rdata, rdata1;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .busy(busy), .err(err)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .ready(ready1), .rvalid(rvalid1), .rdata(rdata1), .busy(busy1), .err(err1)
  );

  always #5 clk = ~clk;

  // One access on the chosen instance; lat counts negedges after acceptance until rvalid (-1 on timeout).
  task automatic do_access(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] got, output logic got_err, output int lat);
    lat = -1;
    got = 'x;
    got_err = 'x;
    @(negedge clk);
    if (sel) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else     begin req  = 1'b1; we  = w; addr  = a; wdata  = d; end
    @(posedge clk);
    #1;
    req = 1'b0;
    req1 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((sel ? rvalid1 : rvalid) === 1'b1) begin
        got = sel ? rdata1 : rdata;
        got_err = sel ? err1 : err;
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    #1;
    n_checks++;
    if ({ready, rvalid, err, busy} !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags got ready/rvalid/err/busy=%b expected 1000", {ready, rvalid, err, busy});
    end
    n_checks++;
    if (rdata !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_rdata got %h expected 00000000", rdata);
    end
    n_checks++;
    if ({ready1, rvalid1, err1, busy1} !== 4'b1000 || rdata1 !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_lat0 got flags=%b rdata=%h expected 1000/00000000",
               {ready1, rvalid1, err1, busy1}, rdata1);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_store_load;
    logic [31:0] got;
    logic ge;
    int lat;
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, got, ge, lat);
    n_checks++;
    if (lat !== 3 || got !== 32'hDEADBEEF || ge !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL store_0x10 got lat=%0d rdata=%h err=%b expected 3/deadbeef/0", lat, got, ge);
    end
    do_access(1'b0, 1'b0, 32'h10, 32'h0, got, ge, lat);
    n_checks++;
    if (lat !== 3 || got !== 32'hDEADBEEF || ge !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL load_0x10 got lat=%0d rdata=%h err=%b expected 3/deadbeef/0", lat, got, ge);
    end
  endtask

  task automatic test_wait_ignore;
    logic [31:0] got;
    logic ge;
    int lat;
    bit bad_ready = 0, bad_busy = 0;
    do_access(1'b0, 1'b1, 32'h14, 32'h11110000, got, ge, lat);
    lat = -1;
    got = 'x;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10; wdata = 32'h0;
    @(posedge clk);
    #1;
    we = 1'b1; addr = 32'h14; wdata = 32'h1234;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready !== 1'b0) bad_ready = 1;
      if (busy !== 1'b1) bad_busy = 1;
      if (rvalid === 1'b1) begin
        got = rdata;
        lat = i;
        req = 1'b0;
        break;
      end
    end
    n_checks++;
    if (lat !== 3 || got !== 32'hDEADBEEF) begin
      n_fail++;
      $display("[TB] FAIL wait_load got lat=%0d rdata=%h expected 3/deadbeef", lat, got);
    end
    n_checks++;
    if (bad_ready || bad_busy) begin
      n_fail++;
      $display("[TB] FAIL wait_stall got bad_ready=%0d bad_busy=%0d expected 0/0", bad_ready, bad_busy);
    end
    do_access(1'b0, 1'b0, 32'h14, 32'h0, got, ge, lat);
    n_checks++;
    if (lat !== 3 || got !== 32'h11110000) begin
      n_fail++;
      $display("[TB] FAIL wait_ignored got lat=%0d mem5=%h expected 3/11110000", lat, got);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] rv_seq, rdy_seq;
    rv_seq = '0;
    rdy_seq = '0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10;
    @(posedge clk);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      rv_seq[i] = rvalid;
      rdy_seq[i] = ready;
    end
    req = 1'b0;
    n_checks++;
    if (rv_seq !== 8'b0010_0010 || rdy_seq !== 8'b0001_0001) begin
      n_fail++;
      $display("[TB] FAIL back_to_back got rvalid=%b ready=%b expected 00100010/00010001", rv_seq, rdy_seq);
    end
    @(negedge clk);
  endtask

`ifndef DMEM_ERR_EN
  task automatic test_wrap;
    logic [31:0] got;
    logic ge;
    int lat;
    do_access(1'b0, 1'b1, 32'h100, 32'hCAFEF00D, got, ge, lat);
    do_access(1'b0, 1'b0, 32'h0, 32'h0, got, ge, lat);
    n_checks++;
    if (lat !== 3 || got !== 32'hCAFEF00D || ge !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wrap_load0 got lat=%0d rdata=%h err=%b expected 3/cafef00d/0", lat, got, ge);
    end
    do_access(1'b0, 1'b0, 32'h13, 32'h0, got, ge, lat);
    n_checks++;
    if (lat !== 3 || got !== 32'hDEADBEEF || ge !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL misaligned_load got lat=%0d rdata=%h err=%b expected 3/deadbeef/0", lat, got, ge);
    end
  endtask
`else
  task automatic test_err;
    logic [31:0] got;
    logic ge;
    int lat;
    do_access(1'b0, 1'b0, 32'h13, 32'h0, got, ge, lat);
    n_checks++;
    if (lat !== 3 || got !== 32'h0 || ge !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL err_misaligned got lat=%0d rdata=%h err=%b expected 3/00000000/1", lat, got, ge);
    end
    do_access(1'b0, 1'b1, 32'h0, 32'h12345678, got, ge, lat);
    do_access(1'b0, 1'b1, 32'h400, 32'h77, got, ge, lat);
    n_checks++;
    if (lat !== 3 || got !== 32'h0 || ge !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL err_range_store got lat=%0d rdata=%h err=%b expected 3/00000000/1", lat, got, ge);
    end
    do_access(1'b0, 1'b0, 32'h0, 32'h0, got, ge, lat);
    n_checks++;
    if (lat !== 3 || got !== 32'h12345678 || ge !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL err_no_write got lat=%0d rdata=%h err=%b expected 3/12345678/0", lat, got, ge);
    end
  endtask
`endif

  task automatic test_reset_abort;
    logic [31:0] got;
    logic ge;
    int lat;
    bit saw_rvalid = 0;
    do_access(1'b0, 1'b1, 32'h20, 32'hAAAA0000, got, ge, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h55;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (ready !== 1'b1 || rvalid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_ready got ready=%b rvalid=%b expected 1/0", ready, rvalid);
    end
    repeat (3) begin
      @(negedge clk);
      if (rvalid !== 1'b0) saw_rvalid = 1;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rvalid !== 1'b0) saw_rvalid = 1;
    end
    n_checks++;
    if (saw_rvalid) begin
      n_fail++;
      $display("[TB] FAIL abort_rvalid got rvalid pulse=1 expected 0");
    end
    do_access(1'b0, 1'b0, 32'h20, 32'h0, got, ge, lat);
    n_checks++;
    if (lat !== 3 || got !== 32'hAAAA0000) begin
      n_fail++;
      $display("[TB] FAIL abort_no_write got lat=%0d rdata=%h expected 3/aaaa0000", lat, got);
    end
  endtask

  task automatic test_latency0;
    logic [31:0] got;
    logic ge;
    int lat;
    logic b0, r0, rv1, b1, rv2, b2;
    @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b0 || ready1 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL lat0_idle got busy=%b ready=%b expected 0/1", busy1, ready1);
    end
    do_access(1'b1, 1'b1, 32'h8, 32'h0BADF00D, got, ge, lat);
    n_checks++;
    if (lat !== 1 || got !== 32'h0BADF00D) begin
      n_fail++;
      $display("[TB] FAIL lat0_store got lat=%0d rdata=%h expected 1/0badf00d", lat, got);
    end
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h8;
    #1;
    b0 = busy1;
    r0 = ready1;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    @(negedge clk);
    rv1 = rvalid1;
    b1 = busy1;
    got = rdata1;
    @(negedge clk);
    rv2 = rvalid1;
    b2 = busy1;
    n_checks++;
    if ({b0, r0, rv1, b1, rv2, b2} !== 6'b111100) begin
      n_fail++;
      $display("[TB] FAIL lat0_timing got busy/ready/rv1/busy1/rv2/busy2=%b expected 111100",
               {b0, r0, rv1, b1, rv2, b2});
    end
    n_checks++;
    if (got !== 32'h0BADF00D) begin
      n_fail++;
      $display("[TB] FAIL lat0_load got %h expected 0badf00d", got);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_wait_ignore();
    test_back_to_back();
`ifndef DMEM_ERR_EN
    test_wrap();
`else
    test_err();
`endif
    test_reset_abort();
    test_latency0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
